// File: rtl/prog_loader.sv
// Host programming stream parser: 8-byte header (address, count) then data bytes,
// emitted as SRAM write requests. Define LOADER_CHECKSUM_EN for a trailing sum byte.
module prog_loader #(
    parameter int ADDR_W      = 19,
    parameter int TIMEOUT_CYC = 0
) (
    input  logic              clock4,
    input  logic              resetn,
    input  logic              enable,
    input  logic [7:0]        rx_data,
    input  logic              rx_valid,
    input  logic              wr_ready,
    output logic [ADDR_W-1:0] wr_address,
    output logic [7:0]        wr_data,
    output logic              wr_store,
    output logic              busy,
    output logic              done,
    output logic              error
);

    localparam logic [3:0] S_HDR0 = 4'd0;
    localparam logic [3:0] S_HDR7 = 4'd7;
    localparam logic [3:0] S_DATA = 4'd8;
`ifdef LOADER_CHECKSUM_EN
    localparam logic [3:0] S_CSUM = 4'd9;
`endif

    logic [3:0]        state;
    logic [ADDR_W-1:0] addr;
    logic [ADDR_W-1:0] cnt;
    logic              rx_vld_p0, rx_vld_p1, rx_vld_p2;
    logic              strobe;
    logic              tmo_hit;

    // Header bytes arrive MSB first; only the low ADDR_W bits survive.
    function automatic logic [ADDR_W-1:0] shift_in(input logic [ADDR_W-1:0] v,
                                                   input logic [7:0] b);
        return ADDR_W'({v, b});
    endfunction

    // Stage p0/p1: synchronizer; p2: edge register for the rising-edge strobe
    always_ff @(posedge clock4 or negedge resetn) begin
        if (!resetn) begin
            rx_vld_p0 <= 1'b0;
            rx_vld_p1 <= 1'b0;
            rx_vld_p2 <= 1'b0;
        end else begin
            rx_vld_p0 <= rx_valid;
            rx_vld_p1 <= rx_vld_p0;
            rx_vld_p2 <= rx_vld_p1;
        end
    end

    assign strobe = rx_vld_p1 & ~rx_vld_p2 & enable;
    assign busy   = (state != S_HDR0) || wr_store;

    generate
        if (TIMEOUT_CYC > 0) begin : g_tmo
            logic [31:0] tmo_cnt;
            always_ff @(posedge clock4 or negedge resetn) begin
                if (!resetn)
                    tmo_cnt <= '0;
                else if (strobe || !enable || state == S_HDR0)
                    tmo_cnt <= '0;
                else
                    tmo_cnt <= tmo_cnt + 32'd1;
            end
            // A strobe on the expiry edge keeps the frame alive.
            assign tmo_hit = (state != S_HDR0) && !strobe && (tmo_cnt == 32'(TIMEOUT_CYC - 1));
        end else begin : g_no_tmo
            assign tmo_hit = 1'b0;
        end
    endgenerate

`ifdef LOADER_CHECKSUM_EN
    logic [7:0] sum;
    always_ff @(posedge clock4 or negedge resetn) begin
        if (!resetn)
            sum <= '0;
        else if (state == S_HDR0)
            sum <= '0;
        else if (state == S_DATA && strobe && !wr_store)
            sum <= sum + rx_data;
    end
`endif

    always_ff @(posedge clock4 or negedge resetn) begin
        if (!resetn) begin
            state      <= S_HDR0;
            addr       <= '0;
            cnt        <= '0;
            wr_address <= '0;
            wr_data    <= '0;
            wr_store   <= 1'b0;
            done       <= 1'b0;
            error      <= 1'b0;
        end else begin
            done <= 1'b0;
            // The handshake runs on its own so an aborted frame still finishes its write.
            if (wr_store && wr_ready)
                wr_store <= 1'b0;

            if (!enable) begin
                state <= S_HDR0;
                error <= 1'b0;
            end else if (tmo_hit) begin
                state <= S_HDR0;
                error <= 1'b1;
            end else if (state <= S_HDR7) begin
                if (strobe) begin
                    if (!state[2])
                        addr <= shift_in(addr, rx_data);
                    else
                        cnt <= shift_in(cnt, rx_data);
                    if (state == S_HDR7) begin
                        if (shift_in(cnt, rx_data) == '0) begin
`ifdef LOADER_CHECKSUM_EN
                            state <= S_CSUM;
`else
                            done  <= 1'b1;
                            state <= S_HDR0;
`endif
                        end else begin
                            state <= S_DATA;
                        end
                    end else begin
                        state <= state + 4'd1;
                    end
                end
            end else if (state == S_DATA) begin
                if (strobe) begin
                    if (wr_store) begin
                        error <= 1'b1;
                    end else begin
                        wr_address <= addr;
                        wr_data    <= rx_data;
                        wr_store   <= 1'b1;
                        addr       <= addr + 1'b1;
                        cnt        <= cnt - 1'b1;
                    end
                end else if (cnt == '0 && (!wr_store || wr_ready)) begin
`ifdef LOADER_CHECKSUM_EN
                    state <= S_CSUM;
`else
                    done  <= 1'b1;
                    state <= S_HDR0;
`endif
                end
`ifdef LOADER_CHECKSUM_EN
            end else if (state == S_CSUM) begin
                if (strobe) begin
                    if (rx_data == sum)
                        done <= 1'b1;
                    else
                        error <= 1'b1;
                    state <= S_HDR0;
                end
`endif
            end else begin
                state <= S_HDR0;
            end
        end
    end

endmodule
